log_add_sched: RTL and testbench
================================

# log_add_sched

Scheduler that shares one log-domain add unit among NREQ requesters. Each requester presents a pair of log operands (characteristic k, truncated mantissa x); the block arbitrates, computes sum_k = k1 + k2 and sum_x = x1 + x2 + 1, and returns the result tagged with the requester index through a valid/ready output register. It sits between the per-lane leading-one/log encoders and the antilog/shift stage of the log multiplier array.

## Interface
- DWIDTH, 16, operand data width; sets characteristic width KW = $clog2(DWIDTH).
- M_WIDTH, 6, truncated mantissa width t.
- NREQ, 4, number of requesters (≥2); IDW = $clog2(NREQ).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant/accept (one-hot or zero).
- req_k1, req_k2  in  NREQ*KW  packed characteristics, requester i at [i*KW +: KW].
- req_x1, req_x2  in  NREQ*M_WIDTH  packed mantissas, requester i at [i*M_WIDTH +: M_WIDTH].
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  downstream accepts result.
- out_sum_k  out  KW+1  k1 + k2.
- out_sum_x  out  M_WIDTH+1  x1 + x2 + 1.
- out_id  out  IDW  index of requester that produced the result.

## Operation
- Two-state output FSM: EMPTY (out_valid=0), FULL (out_valid=1).
- can_accept = EMPTY or (FULL and out_ready). Arbitration happens only when can_accept.
- When can_accept and any req_valid: exactly one req_ready bit asserts (winner g); operands of g are added and loaded into the output register with out_id=g; state → FULL.
- FULL and out_ready and no req_valid: state → EMPTY. FULL and not out_ready: register and out_id hold stable; all req_ready=0.
- EMPTY and no req_valid: stay EMPTY, req_ready=0.
- Transfer on requester side = req_valid[i] & req_ready[i]; requesters must hold operands stable while valid and unaccepted. req_ready is combinational from req_valid, state and out_ready; it must not depend on requester operands.
- Arithmetic: sum_k = zero-extended k1 + k2 in KW+1 bits; sum_x = x1 + x2 + 1 in M_WIDTH+1 bits. Neither overflows (max 2^(M_WIDTH+1)−1 and 2·(DWIDTH−1)); no saturation logic.
- Priority pointer ptr (IDW bits) selects first candidate; search ptr, ptr+1, … modulo NREQ. After grant to g, ptr ← (g+1) mod NREQ, wrapping NREQ−1 → 0.
- Reset mid-operation: any held result is discarded, state → EMPTY, no req_ready asserted during reset.

## Timing
- Reset values: out_valid=0, out_sum_k=0, out_sum_x=0, out_id=0, ptr=0, req_ready=0.
- Latency: grant in cycle n → result on outputs cycle n+1 (out_valid=1).
- Throughput: one result per cycle when out_ready held high and requests pending (back-to-back, no bubble).
- Simultaneous drain and grant in FULL: old result consumed and new result loaded at the same edge.
- Backpressure: out_ready=0 stalls indefinitely with no loss and no duplicate grants.

## Configuration
- LOG_SCHED_RR_EN defined: round-robin arbitration using ptr as above; starvation-free.
- Not defined: fixed priority, lowest index wins; ptr register removed (reads as 0).

## Test plan
- Reset: rst_n low mid-stream with out_valid=1 → all outputs 0, req_ready=0 asynchronously; first grant after release goes to requester 0.
- Single request: req 2 valid, k1=15,k2=15,x1=63,x2=63, out_ready=1 → req_ready=4'b0100 that cycle; next cycle out_valid=1, out_sum_k=30, out_sum_x=127, out_id=2.
- Round robin (LOG_SCHED_RR_EN): all four valid continuously, out_ready=1 → grants 0,1,2,3,0 on consecutive cycles, out_id follows one cycle later, no bubbles.
- Fixed priority (macro undefined): all four valid → requester 0 granted every cycle; others never granted until req_valid[0] drops.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with req 1 valid → outputs stable, req_ready=0; out_ready=1 → req 1 granted same cycle, new result next cycle.
- Wrap-around: ptr=3 (RR), requests 0 and 3 valid → 3 granted, ptr→0; next cycle 0 granted.

Source files
------------

// File: rtl/log_add_sched.sv
// Shared log-domain adder scheduler: arbitrates NREQ operand pairs into one registered result.
// Optional LOG_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module log_add_sched #(
   parameter int DWIDTH  = 16,
   parameter int M_WIDTH = 6,
   parameter int NREQ    = 4,
   localparam int KW     = $clog2(DWIDTH),
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*KW-1:0]      req_k1,
   input  logic [NREQ*KW-1:0]      req_k2,
   input  logic [NREQ*M_WIDTH-1:0] req_x1,
   input  logic [NREQ*M_WIDTH-1:0] req_x2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [KW:0]             out_sum_k,
   output logic [M_WIDTH:0]        out_sum_x,
   output logic [IDW-1:0]          out_id
);

   // state   | meaning
   // EMPTY   | output register holds no result
   // FULL    | output register holds a result awaiting out_ready
   localparam logic [0:0] S_EMPTY = 1'b0;
   localparam logic [0:0] S_FULL  = 1'b1;

   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   logic [0:0]       state;
   logic [IDW-1:0]   ptr;
   logic             can_accept;
   logic             any_valid;
   logic [IDW-1:0]   grant_id;
   logic [IDW:0]     cand;
   logic [KW-1:0]    k1;
   logic [KW-1:0]    k2;
   logic [M_WIDTH-1:0] x1;
   logic [M_WIDTH-1:0] x2;
   logic [KW:0]      sum_k;
   logic [M_WIDTH:0] sum_x;

   assign can_accept = (state == S_EMPTY) || out_ready;

   // Search starts at ptr and wraps modulo NREQ; ptr is fixed at 0 for fixed priority.
   always_comb begin
      any_valid = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + (IDW+1)'(i);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!any_valid && req_valid[cand[IDW-1:0]]) begin
            any_valid = 1'b1;
            grant_id  = cand[IDW-1:0];
         end
      end
   end

   // Gated by rst_n so no requester sees an accept while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && can_accept && any_valid) req_ready[grant_id] = 1'b1;
   end

   assign k1    = req_k1[grant_id*KW +: KW];
   assign k2    = req_k2[grant_id*KW +: KW];
   assign x1    = req_x1[grant_id*M_WIDTH +: M_WIDTH];
   assign x2    = req_x2[grant_id*M_WIDTH +: M_WIDTH];
   assign sum_k = {1'b0, k1} + {1'b0, k2};
   assign sum_x = {1'b0, x1} + {1'b0, x2} + (M_WIDTH+1)'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_EMPTY;
         out_sum_k <= '0;
         out_sum_x <= '0;
         out_id    <= '0;
      end else if (can_accept) begin
         if (any_valid) begin
            state     <= S_FULL;
            out_sum_k <= sum_k;
            out_sum_x <= sum_x;
            out_id    <= grant_id;
         end else begin
            state <= S_EMPTY;
         end
      end
   end

   assign out_valid = (state == S_FULL);

`ifdef LOG_SCHED_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (can_accept && any_valid) begin
         ptr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
      end
   end
`else
   assign ptr = '0;
`endif

endmodule

// File: tb/tb_log_add_sched.sv
// Directed bench for log_add_sched; arbitration checks follow LOG_SCHED_RR_EN when defined.
module tb_log_add_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_k1;
   logic [15:0] req_k2;
   logic [23:0] req_x1;
   logic [23:0] req_x2;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_sum_k;
   logic [6:0]  out_sum_x;
   logic [1:0]  out_id;

   int errors = 0;
   int checks = 0;

   log_add_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_k1(req_k1), .req_k2(req_k2), .req_x1(req_x1), .req_x2(req_x2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum_k(out_sum_k), .out_sum_x(out_sum_x), .out_id(out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default operands: k1=i+1, k2=2i, x1=10i+3, x2=i+5 -> sum_k=3i+1, sum_x=11i+9
   function automatic logic [4:0] exp_k(int i);
      return 5'(3*i + 1);
   endfunction
   function automatic logic [6:0] exp_x(int i);
      return 7'(11*i + 9);
   endfunction

   task automatic set_default_operands();
      for (int i = 0; i < 4; i++) begin
         req_k1[i*4 +: 4] = 4'(i + 1);
         req_k2[i*4 +: 4] = 4'(2*i);
         req_x1[i*6 +: 6] = 6'(10*i + 3);
         req_x2[i*6 +: 6] = 6'(i + 5);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'b0000;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      set_default_operands();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_sum_k, out_sum_x, out_id} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b k=%0d x=%0d id=%0d, want all 0", out_valid, out_sum_k, out_sum_x, out_id);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      req_k1[8 +: 4] = 4'd15; req_k2[8 +: 4] = 4'd15;
      req_x1[12 +: 6] = 6'd63; req_x2[12 +: 6] = 6'd63;
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum_k !== 5'd30 || out_sum_x !== 7'd127 || out_id !== 2'd2) begin
         errors++;
         $display("FAIL single_result: got valid=%b k=%0d x=%0d id=%0d, want 1 30 127 2", out_valid, out_sum_k, out_sum_x, out_id);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got out_valid=%b want 0", out_valid);
      end
      set_default_operands();
   endtask

   task automatic test_arbitration();
      logic [1:0] exp_id;
      apply_reset();
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
`ifdef LOG_SCHED_RR_EN
         exp_id = 2'(c % 4);
`else
         exp_id = 2'd0;
`endif
         #1;
         checks++;
         if (req_ready !== (4'b0001 << exp_id)) begin
            errors++;
            $display("FAIL arb_ready[%0d]: got %b want id %0d", c, req_ready, exp_id);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_id !== exp_id || out_sum_k !== exp_k(int'(exp_id)) || out_sum_x !== exp_x(int'(exp_id))) begin
            errors++;
            $display("FAIL arb_result[%0d]: got valid=%b id=%0d k=%0d x=%0d want id %0d", c, out_valid, out_id, out_sum_k, out_sum_x, exp_id);
         end
         @(negedge clk);
      end
`ifndef LOG_SCHED_RR_EN
      req_valid = 4'b1110;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL fixed_next: got %b want 0010", req_ready);
      end
`endif
      req_valid = 4'b0000;
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_valid = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b0010;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd0 || out_sum_k !== exp_k(0) || out_sum_x !== exp_x(0)) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b id=%0d k=%0d x=%0d want 1 0 1 9", c, out_valid, out_id, out_sum_k, out_sum_x);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b want 0010", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum_k !== exp_k(1) || out_sum_x !== exp_x(1)) begin
         errors++;
         $display("FAIL bp_release_result: got valid=%b id=%0d k=%0d x=%0d want 1 1 4 20", out_valid, out_id, out_sum_k, out_sum_x);
      end
      @(negedge clk);
      req_valid = 4'b0000;
   endtask

   task automatic test_wrap();
      apply_reset();
`ifdef LOG_SCHED_RR_EN
      req_valid = 4'b0100;
      @(posedge clk);
      @(negedge clk);
      req_valid = 4'b1001;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL wrap_first: got %b want 1000", req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_second: got %b want 0001", req_ready);
      end
`else
      req_valid = 4'b1001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL wrap_fixed: got %b want 0001", req_ready);
      end
`endif
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== `ifdef LOG_SCHED_RR_EN 2'd0 `else 2'd0 `endif || out_sum_k !== exp_k(0)) begin
         errors++;
         $display("FAIL wrap_result: got valid=%b id=%0d k=%0d want 1 0 1", out_valid, out_id, out_sum_k);
      end
      @(negedge clk);
      req_valid = 4'b0000;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_valid = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      req_valid = 4'b1111;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_sum_k, out_sum_x, out_id} !== 15'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got valid=%b k=%0d x=%0d id=%0d, want all 0", out_valid, out_sum_k, out_sum_x, out_id);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_ready: got %b want 0000", req_ready);
      end
      @(negedge clk);
      out_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL mid_reset_first_grant: got %b want 0001", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_sum_x !== exp_x(0)) begin
         errors++;
         $display("FAIL mid_reset_result: got valid=%b id=%0d x=%0d want 1 0 9", out_valid, out_id, out_sum_x);
      end
      @(negedge clk);
      req_valid = 4'b0000;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 4'b0000;
      out_ready = 1'b1;
      req_k1 = '0; req_k2 = '0; req_x1 = '0; req_x2 = '0;
      test_reset();
      test_single();
      test_arbitration();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
